// File: rtl/frame_sequencer_if.sv
// Handshake/control bundle between software config, frame_sequencer and its consumers.
// Inputs are driven by the master side; strobes and status come back from the slave.
interface frame_sequencer_if;
    logic       iEnable;
    logic       iWrite;
    logic       iMode;
    logic       iIrq_inhibit;
    logic       iIrq_ack;
    logic       oQuarter_frame;
    logic       oHalf_frame;
    logic       oIrq;
    logic [2:0] oStep;

    modport master (
        output iEnable,
        output iWrite,
        output iMode,
        output iIrq_inhibit,
        output iIrq_ack,
        input  oQuarter_frame,
        input  oHalf_frame,
        input  oIrq,
        input  oStep
    );

    modport slave (
        input  iEnable,
        input  iWrite,
        input  iMode,
        input  iIrq_inhibit,
        input  iIrq_ack,
        output oQuarter_frame,
        output oHalf_frame,
        output oIrq,
        output oStep
    );
endinterface

// File: rtl/frame_sequencer.sv
// Audio frame sequencer: divides clk into frame steps and emits quarter/half
// frame strobes plus a sticky frame IRQ, in 4-step or 5-step mode.
module frame_sequencer #(
    parameter int STEP_CYCLES = 7457,
    parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
    input  logic             clk,
    input  logic             iReset_n,
    frame_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic             mode_q, mode_d;
    logic             inh_q, inh_d;
    logic             irq_q, irq_d;
    logic             qf_q, qf_d;
    logic             hf_q, hf_d;
    logic [2:0]       step_last;
    logic             tick;

    assign step_last = mode_q ? 3'd4 : 3'd3;
    assign tick      = bus.iEnable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        mode_d = mode_q;
        inh_d  = inh_q;
        irq_d  = irq_q & ~bus.iIrq_ack;
        qf_d   = 1'b0;
        hf_d   = 1'b0;
        if (bus.iWrite) begin
            // A write restarts the frame and swallows a coincident tick.
            mode_d = bus.iMode;
            inh_d  = bus.iIrq_inhibit;
            cnt_d  = '0;
            step_d = 3'd0;
            if (bus.iIrq_inhibit)
                irq_d = 1'b0;
            qf_d = bus.iMode;
            hf_d = bus.iMode;
        end else if (tick) begin
            cnt_d  = '0;
            step_d = (step_q >= step_last) ? 3'd0 : step_q + 3'd1;
            unique case (1'b1)
                step_q == 3'd0: qf_d = 1'b1;
                step_q == 3'd1: begin
                    qf_d = 1'b1;
                    hf_d = 1'b1;
                end
                step_q == 3'd2: qf_d = 1'b1;
                step_q == 3'd3: begin
                    qf_d = ~mode_q;
                    hf_d = ~mode_q;
                    if (!mode_q && !inh_q)
                        irq_d = 1'b1;
                end
                default: begin
                    qf_d = mode_q;
                    hf_d = mode_q;
                end
            endcase
        end else if (bus.iEnable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            cnt_q  <= '0;
            step_q <= 3'd0;
            mode_q <= 1'b0;
            inh_q  <= 1'b0;
            irq_q  <= 1'b0;
            qf_q   <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            mode_q <= mode_d;
            inh_q  <= inh_d;
            irq_q  <= irq_d;
            qf_q   <= qf_d;
            hf_q   <= hf_d;
        end
    end

    assign bus.oQuarter_frame = qf_q;
    assign bus.oHalf_frame    = hf_q;
    assign bus.oIrq           = irq_q;
    assign bus.oStep          = step_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: vector table, directed corner sequences and
// randomized traffic checked against a frame-count reference model.
module tb_frame_sequencer;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;

    frame_sequencer_if sif();

    frame_sequencer #(.STEP_CYCLES(S)) dut (
        .clk      (clk),
        .iReset_n (rst_n),
        .bus      (sif)
    );

    always #5 clk = ~clk;

    // Reference model: n counts enabled cycles since reset/write.
    int         n = 0;
    bit         m_mode = 0, m_inh = 0, m_irq = 0, m_q = 0, m_h = 0;
    logic [4:0] qmask [2] = '{5'b01111, 5'b10111};
    logic [4:0] hmask [2] = '{5'b01010, 5'b10010};

    function automatic int m_len();
        return m_mode ? 5 : 4;
    endfunction

    always @(posedge clk) begin
        int c;
        if (!rst_n) begin
            n = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0;
        end else if (sif.iWrite) begin
            m_mode = sif.iMode;
            m_inh  = sif.iIrq_inhibit;
            n = 0;
            if (sif.iIrq_inhibit || sif.iIrq_ack) m_irq = 0;
            m_q = sif.iMode;
            m_h = sif.iMode;
        end else begin
            m_q = 0;
            m_h = 0;
            if (sif.iIrq_ack) m_irq = 0;
            if (sif.iEnable) begin
                n++;
                if (n % S == 0) begin
                    c = (n / S - 1) % m_len();
                    m_q = qmask[m_mode][c];
                    m_h = hmask[m_mode][c];
                    if (!m_mode && c == 3 && !m_inh) m_irq = 1;
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [5:0] act;
            logic [5:0] exp;
            act = {sif.oQuarter_frame, sif.oHalf_frame, sif.oIrq, sif.oStep};
            exp = {m_q, m_h, m_irq, 3'((n / S) % m_len())};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model: got %b want %b at %0t", act, exp, $time);
            end
        end
    end

    task automatic cyc(bit en, bit wr, bit md, bit inh, bit ack, bit rn);
        sif.iEnable      = en;
        sif.iWrite       = wr;
        sif.iMode        = md;
        sif.iIrq_inhibit = inh;
        sif.iIrq_ack     = ack;
        rst_n            = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) cyc(1, 0, 0, 0, 0, 1);
    endtask

    typedef struct {
        bit         rn, en, wr, md, inh, ack;
        bit         q, h, irq;
        logic [2:0] step;
    } vec_t;

    vec_t tbl [19];
    int   irq_seen;

    initial begin
        tbl[0] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 3'd0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{1, 1, 0, 0, 0, 0, (i % 4 == 0), (i % 8 == 0),
                       (i == 16), 3'((i / 4) % 4)};
        tbl[17] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 3'd0};
        tbl[18] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 3'd0};

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].en, tbl[i].wr, tbl[i].md, tbl[i].inh, tbl[i].ack, tbl[i].rn);
            chk($sformatf("vec%0d", i),
                {sif.oQuarter_frame, sif.oHalf_frame, sif.oIrq, sif.oStep},
                {tbl[i].q, tbl[i].h, tbl[i].irq, tbl[i].step});
            chk_on = 1'b1;
        end

        // 5-step frame after the write in the last table row
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 0, 0, 0, 0, 1);
            if (i == 16) chk("5step_gap", sif.oQuarter_frame, 0);
            if (i == 20) chk("5step_last", {sif.oQuarter_frame, sif.oHalf_frame, sif.oIrq}, 3'b110);
        end

        // ack on the IRQ-set edge: set wins, then ack clears
        cyc(1, 1, 0, 0, 0, 1);
        run(15);
        cyc(1, 0, 0, 0, 1, 1);
        chk("ack_vs_set", {sif.oQuarter_frame, sif.oHalf_frame, sif.oIrq}, 3'b111);
        cyc(1, 0, 0, 0, 1, 1);
        chk("ack_clear", sif.oIrq, 0);

        // write on a tick edge swallows the tick
        cyc(1, 1, 0, 0, 0, 1);
        run(3);
        cyc(1, 1, 0, 0, 0, 1);
        chk("wr_tick", {sif.oQuarter_frame, sif.oHalf_frame, sif.oStep}, 0);
        run(3);
        chk("wr_tick_q3", sif.oQuarter_frame, 0);
        run(1);
        chk("wr_tick_q4", {sif.oQuarter_frame, sif.oStep}, {1'b1, 3'd1});

        // enable hold with cnt=2
        cyc(1, 1, 0, 0, 0, 1);
        run(2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("hold_q", sif.oQuarter_frame, 0);
        run(1);
        chk("hold_t1", sif.oQuarter_frame, 0);
        run(1);
        chk("hold_t2", sif.oQuarter_frame, 1);

        // reset at step 3 cnt 3 from 5-step mode, then 4-step afterwards
        cyc(1, 1, 1, 0, 0, 1);
        run(15);
        chk("pre_rst_step", sif.oStep, 3);
        cyc(1, 1, 1, 0, 1, 0);
        chk("rst_mid", {sif.oQuarter_frame, sif.oHalf_frame, sif.oIrq, sif.oStep}, 0);
        run(16);
        chk("rst_4step", {sif.oIrq, sif.oStep}, {1'b1, 3'd0});

        // inhibit write clears IRQ; none across 3 frames
        cyc(1, 1, 0, 1, 0, 1);
        chk("inh_clear", sif.oIrq, 0);
        irq_seen = 0;
        for (int i = 0; i < 3 * 4 * S; i++) begin
            run(1);
            irq_seen |= int'(sif.oIrq);
        end
        chk("inh_never", irq_seen, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 299) != 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame sequencer for the audio channel path: divides the system clock into fixed-length frame steps and emits single-cycle quarter-frame and half-frame strobes, plus a frame interrupt. It sits directly upstream of `frequency`. `oHalf_frame` drives `frequency.iSweep_clk`, and `frequency` rising-edge detects it. `oQuarter_frame` is reserved for the envelope stage. Software reconfigures it through a single write strobe.

## Interface
- `STEP_CYCLES`, default 7457: `clk` cycles per frame step; must be ≥ 2.
- `CNT_W`, default `$clog2(STEP_CYCLES)`: width of the step-cycle counter.

- `clk` input 1: system clock; all logic on the rising edge.
- `iReset_n` input 1: reset, synchronous and active-low.
- `iEnable` input 1: when low, the cycle counter holds and no step ticks occur.
- `iWrite` input 1: one-cycle configuration strobe; samples `iMode` and `iIrq_inhibit`.
- `iMode` input 1: 0 selects 4-step mode, 1 selects 5-step mode.
- `iIrq_inhibit` input 1: 1 prevents setting the IRQ flag and clears it on write.
- `iIrq_ack` input 1: one-cycle clear of the IRQ flag.
- `oQuarter_frame` output 1: one-cycle quarter-frame strobe.
- `oHalf_frame` output 1: one-cycle half-frame strobe; feeds the sweep clock.
- `oIrq` output 1: frame IRQ flag, level output.
- `oStep` output 3: current step index.

## Operation
- **State**
  - `cnt[CNT_W-1:0]`, `step[2:0]`, registered `mode`, registered `inhibit`, IRQ flag.
  - All outputs are registered.
- **Reset** (`iReset_n`=0 at an edge):
  - `cnt`=0, `step`=0, `mode`=0, `inhibit`=0.
  - `oQuarter_frame`=0, `oHalf_frame`=0, `oIrq`=0, `oStep`=0.
  - Reset mid-step discards all progress and any pending strobe.
- **Counting**
  - With `iEnable`=1, `cnt` increments each cycle.
  - A tick occurs at an edge where `cnt`==STEP_CYCLES-1. On that edge `cnt`←0 and `step` advances.
  - With `iEnable`=0, `cnt` and `step` hold, and strobes are 0.
- **4-step mode**: steps 0→1→2→3→0. On completing:
  - step 0: quarter.
  - step 1: quarter + half.
  - step 2: quarter.
  - step 3: quarter + half; IRQ flag set if `inhibit`=0.
- **5-step mode**: steps 0→1→2→3→4→0. On completing:
  - step 0: quarter.
  - step 1: quarter + half.
  - step 2: quarter.
  - step 3: no strobes.
  - step 4: quarter + half.
  - IRQ is never set in 5-step mode.
- **Write** (`iWrite`=1):
  - `mode`←`iMode`, `inhibit`←`iIrq_inhibit`, `cnt`←0, `step`←0.
  - If `iIrq_inhibit`=1, the IRQ flag clears.
  - If `iMode`=1, quarter and half strobe immediately (next cycle), regardless of `iEnable`.
- **IRQ**
  - The flag is sticky until `iIrq_ack` or a write with inhibit=1.
  - `iIrq_ack` is ignored when the flag is already 0.
- **Width rules**
  - `cnt` never exceeds STEP_CYCLES-1.
  - `step` never exceeds 3 in 4-step mode or 4 in 5-step mode.
  - A write into 4-step mode from step 4 restarts at step 0; no illegal step is reachable.

## Timing
- **Strobe latency**
  - Strobes are asserted for exactly one cycle, in the cycle following the tick edge.
  - They are decoded from the step being completed.
  - `oStep` shows the new step in the same cycle as the strobe.
- **First tick**
  - The first tick after reset or a write occurs STEP_CYCLES enabled cycles later.
  - Step period is exactly STEP_CYCLES enabled cycles; there is no drift across wrap-around.
- **IRQ latency**: `oIrq` rises in the same cycle as the step-3 strobes.
- **Simultaneous events**
  - Write + tick on the same edge: the write wins. The tick is discarded with no tick strobes and no IRQ set. Only the 5-step immediate strobes appear, if `iMode`=1.
  - `iIrq_ack` + IRQ set on the same edge: set wins, and `oIrq` stays 1.
  - `iIrq_ack` + write with inhibit=1: `oIrq`=0.
  - Reset + any input on the same edge: reset wins.
- **Downstream compatibility**
  - Consecutive `oHalf_frame` strobes are separated by ≥ STEP_CYCLES cycles.
  - A single-cycle high is sufficient for `frequency`'s two-flop edge detector.

## Test plan
- **Reset, 4-step sequence** (STEP_CYCLES=4, `iEnable`=1, reset released):
  - Quarter strobes appear on cycles 5, 9, 13, 17.
  - Half strobes appear on cycles 9 and 17.
  - `oIrq` rises on cycle 17 and stays high.
  - `oStep` sequence is 1,2,3,0.
- **5-step write** (`iWrite`, `iMode`=1):
  - Quarter + half appear the next cycle.
  - Then quarter strobes at +4, +8, +12 and +20 cycles.
  - Half strobes at +8 and +20.
  - No strobe at +16; `oIrq` stays 0 throughout.
- **IRQ control**
  - With `oIrq`=1, pulse `iIrq_ack` → `oIrq`=0 next cycle.
  - Write inhibit=1 in 4-step mode → `oIrq` never sets across 3 full frames.
- **Simultaneous events**
  - Assert `iIrq_ack` on the IRQ-set edge → `oIrq`=1.
  - Assert `iWrite` (`iMode`=0) on a tick edge → no strobe, `oStep`=0, next quarter 4 cycles later.
- **Enable hold**: drop `iEnable` for 10 cycles mid-step with `cnt`=2 → no strobes. After re-enable, the tick occurs 2 cycles later.
- **Reset mid-operation**: assert `iReset_n`=0 at step 3, `cnt`=3 → next cycle all outputs 0, no pending strobe. After release, mode is 4-step.
